// File: rtl/apb4_reg_bridge.sv
// APB4 slave to simple req/ack register bus bridge.
// Each APB transfer becomes one held request with a bounded ack wait, a misalignment check and an error counter.
`timescale 1ns/1ps
module apb4_reg_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  reg_req,
    output logic                  reg_we,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic                  reg_ack,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    input  logic                  reg_err,
    output logic [7:0]            err_cnt
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_tcnt;
    logic             r_aband;
    logic             w_tmo;
    logic             w_drop;

    assign w_tmo  = (r_tcnt == CNT_W'(TIMEOUT_CYCLES));
    // Master gave up on this transfer: finish the register access but never answer it.
    assign w_drop = r_aband | ~psel;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state   <= IDLE;
            r_tcnt    <= '0;
            r_aband   <= 1'b0;
            prdata    <= '0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            reg_req   <= 1'b0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            err_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (psel && !penable) begin
                        reg_we    <= pwrite;
                        reg_addr  <= paddr;
                        reg_wdata <= pwdata;
                        r_aband   <= 1'b0;
                        if (paddr[1:0] == 2'b00) begin
                            reg_req <= 1'b1;
                            r_tcnt  <= CNT_W'(1);
                            r_state <= REQ;
                        end else begin
                            pready  <= 1'b1;
                            pslverr <= 1'b1;
                            prdata  <= '0;
                            r_state <= RESP;
                        end
                    end
                end
                REQ: begin
                    if (!psel) r_aband <= 1'b1;
                    // Ack is checked first so an ack on the final cycle beats the timeout.
                    if (reg_ack || w_tmo) begin
                        reg_req <= 1'b0;
                        r_tcnt  <= '0;
                        if (w_drop) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= RESP;
                            pready  <= 1'b1;
                            if (reg_ack) begin
                                prdata  <= reg_we ? '0 : reg_rdata;
                                pslverr <= reg_err;
                            end else begin
                                prdata  <= '0;
                                pslverr <= 1'b1;
                            end
                        end
                    end else begin
                        r_tcnt <= r_tcnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (!psel || penable) begin
                        r_state <= IDLE;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        prdata  <= '0;
                        if (psel && pslverr && err_cnt != 8'hFF)
                            err_cnt <= err_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb4_reg_bridge.sv
// Self-checking bench for apb4_reg_bridge: directed vector table, corner sequences,
// and random transfers scored against a transaction-level model.
`timescale 1ns/1ps
module tb_apb4_reg_bridge;
    localparam int TMO = 16;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic        reg_req, reg_we;
    logic [31:0] reg_addr, reg_wdata, reg_rdata;
    logic        reg_ack, reg_err;
    logic [7:0]  err_cnt;

    int n_err = 0;
    int n_chk = 0;
    int mcnt  = 0;

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [31:0] wd;
        int          dly;
        logic [31:0] rd;
        logic        er;
        int          e_req;
        int          e_lat;
        logic        e_se;
        logic [31:0] e_pr;
        int          e_cnt;
    } vec_t;

    vec_t tbl [8];

    apb4_reg_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err), .err_cnt(err_cnt)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Spec-level outcome of one transfer: wait cycles before ack decide everything.
    function automatic void model(input logic [31:0] a, input logic we, input int dly,
                                  input logic [31:0] rd, input logic er,
                                  output int ereq, output int elat, output logic ese,
                                  output logic [31:0] epr);
        logic [1:0] lo;
        lo = a[1:0];
        if (lo != 2'b00) begin
            ereq = 0; elat = 1; ese = 1'b1; epr = '0;
        end else if (dly + 1 > TMO) begin
            ereq = TMO; elat = TMO + 1; ese = 1'b1; epr = '0;
        end else begin
            ereq = dly + 1; elat = dly + 2; ese = er; epr = we ? 32'h0 : rd;
        end
    endfunction

    // Called just after a rising edge; the next edge is the setup edge T0.
    task automatic do_xfer(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           input int dly, input logic [31:0] rd, input logic er,
                           output int nreq, output int lat, output logic se,
                           output logic [31:0] pr, output logic pay_ok);
        bit got;
        nreq = 0; lat = -1; se = 1'b0; pr = '0; pay_ok = 1'b1; got = 0;
        psel = 1'b1; penable = 1'b0; pwrite = we; paddr = a; pwdata = wd;
        reg_rdata = rd; reg_err = er; reg_ack = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            if (pready) begin
                got = 1; lat = cyc; se = pslverr; pr = prdata;
                reg_ack = 1'($urandom_range(0, 1));
            end else if (reg_req) begin
                nreq++;
                if (reg_we !== we || reg_addr !== a || reg_wdata !== wd) pay_ok = 1'b0;
                reg_ack = (nreq == dly + 1);
            end else begin
                reg_ack = 1'b0;
            end
            @(posedge pclk); #1;
        end
        psel = 1'b0; penable = 1'b0; reg_ack = 1'b0;
        if (!got) begin
            n_chk++; n_err++;
            $display("FAIL xfer_timeout: no pready within 40 cycles, addr 0x%0h", a);
        end
    endtask

    task automatic check_xfer(input string tag, input vec_t v);
        int nreq, lat;
        logic se, ok;
        logic [31:0] pr;
        do_xfer(v.a, v.we, v.wd, v.dly, v.rd, v.er, nreq, lat, se, pr, ok);
        chk({tag, ".req_cycles"}, 64'(nreq), 64'(v.e_req));
        chk({tag, ".latency"},    64'(lat),  64'(v.e_lat));
        chk({tag, ".pslverr"},    64'(se),   64'(v.e_se));
        chk({tag, ".prdata"},     64'(pr),   64'(v.e_pr));
        chk({tag, ".payload"},    64'(ok),   64'd1);
        chk({tag, ".pready_off"}, 64'(pready), 64'd0);
        chk({tag, ".err_cnt"},    64'(err_cnt), 64'(v.e_cnt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   nreq, lat;
        logic se, ok, seen;
        logic [31:0] pr;

        //          addr          we    wdata         dly  rdata         er    req lat se    prdata        cnt
        tbl[0] = '{32'h10, 1'b1, 32'hDEADBEEF, 0,   32'hFFFFFFFF, 1'b0, 1,  2,  1'b0, 32'h0,        0};
        tbl[1] = '{32'h20, 1'b0, 32'h0,        3,   32'h12345678, 1'b0, 4,  5,  1'b0, 32'h12345678, 0};
        tbl[2] = '{32'h21, 1'b0, 32'h0,        0,   32'h55555555, 1'b0, 0,  1,  1'b1, 32'h0,        1};
        tbl[3] = '{32'h30, 1'b0, 32'h0,        100, 32'h77777777, 1'b0, 16, 17, 1'b1, 32'h0,        2};
        tbl[4] = '{32'h40, 1'b0, 32'h0,        15,  32'hCAFEF00D, 1'b0, 16, 17, 1'b0, 32'hCAFEF00D, 2};
        tbl[5] = '{32'h44, 1'b1, 32'h0BADF00D, 2,   32'hFFFFFFFF, 1'b1, 3,  4,  1'b1, 32'h0,        3};
        tbl[6] = '{32'h48, 1'b0, 32'h0,        1,   32'h0000A5A5, 1'b1, 2,  3,  1'b1, 32'h0000A5A5, 4};
        tbl[7] = '{32'h4E, 1'b1, 32'h13572468, 0,   32'hFFFFFFFF, 1'b0, 0,  1,  1'b1, 32'h0,        5};

        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; reg_ack = 1'b0; reg_rdata = '0; reg_err = 1'b0;
        #12;
        chk("reset.outs", 64'({prdata, pready, pslverr, reg_req, reg_we, err_cnt}), 64'd0);
        chk("reset.payload", 64'({reg_addr, reg_wdata}), 64'd0);
        @(posedge pclk); #1;
        presetn = 1'b1;

        for (int i = 0; i < 8; i++) check_xfer($sformatf("vec%0d", i), tbl[i]);
        mcnt = 5;

        // Master drops psel while the register access is outstanding.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h50; reg_ack = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        chk("drop.req_up", 64'(reg_req), 64'd1);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        chk("drop.req_held", 64'(reg_req), 64'd1);
        reg_ack = 1'b1;
        @(posedge pclk); #1;
        reg_ack = 1'b0;
        chk("drop.req_clr", 64'(reg_req), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (pready) seen = 1'b1;
            @(posedge pclk); #1;
        end
        chk("drop.no_pready", 64'(seen), 64'd0);
        chk("drop.err_cnt", 64'(err_cnt), 64'(mcnt));

        for (int i = 0; i < 60; i++) begin
            v.a   = {$urandom_range(0, 255), 2'b00} | (($urandom_range(0, 3) == 0) ? 32'(1 + $urandom_range(0, 2)) : 32'h0);
            v.we  = 1'($urandom_range(0, 1));
            v.wd  = $urandom;
            v.dly = $urandom_range(0, 20);
            v.rd  = $urandom;
            v.er  = ($urandom_range(0, 4) == 0);
            model(v.a, v.we, v.dly, v.rd, v.er, v.e_req, v.e_lat, v.e_se, v.e_pr);
            if (v.e_se) mcnt = (mcnt == 255) ? 255 : mcnt + 1;
            v.e_cnt = mcnt;
            check_xfer($sformatf("rnd%0d", i), v);
        end

        // Asynchronous reset in the middle of a pending request.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h60; pwdata = 32'hA5A5A5A5;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (3) @(posedge pclk);
        #3;
        chk("arst.pre_req", 64'(reg_req), 64'd1);
        presetn = 1'b0;
        #1;
        chk("arst.outs", 64'({prdata, pready, pslverr, reg_req, reg_we, err_cnt}), 64'd0);
        chk("arst.payload", 64'({reg_addr, reg_wdata}), 64'd0);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        presetn = 1'b1;
        mcnt = 0;
        v = '{32'h64, 1'b1, 32'h600DCAFE, 0, 32'h0, 1'b0, 1, 2, 1'b0, 32'h0, 0};
        check_xfer("arst.post", v);

        // Drive the error counter into saturation with misaligned accesses.
        for (int i = 0; i < 258; i++) begin
            do_xfer(32'h3, 1'b0, 32'h0, 0, 32'h0, 1'b0, nreq, lat, se, pr, ok);
            mcnt = (mcnt == 255) ? 255 : mcnt + 1;
        end
        chk("sat.err_cnt", 64'(err_cnt), 64'd255);
        chk("sat.model", 64'(err_cnt), 64'(mcnt));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
